// File: rtl/key_scanner.sv
// key_scanner: synchronises, debounces and priority-encodes seven push-buttons
// into a Hack keyboard code, with a one-cycle press strobe and typematic repeat.
// Ports: clk (rising edge); rst (synchronous, active-high); key[6:0] raw levels;
//        stable[6:0] debounced keys (1 = pressed); code[15:0] keyboard code (0 = none);
//        press: one-cycle strobe on a new key code or on an auto-repeat.
// Latency: raw change -> stable after 2+DB_CYCLES edges -> code/press one edge later.
module key_scanner #(
  parameter int DB_CYCLES    = 1000000,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_RATE  = 10000000,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  key,
  output logic [6:0]  stable,
  output logic [15:0] code,
  output logic        press
);

  localparam int DBW  = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCW  = (RMAX < 2) ? 1 : $clog2(RMAX);

  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [RCW-1:0] RD_LAST = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] RR_LAST = RCW'(REPEAT_RATE - 1);

  // Raw level of a released button; the synchroniser starts out "released".
  localparam logic [6:0] REL_LEVEL = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT
  } rpt_state_e;

  logic [6:0]     sync1_q, sync2_q;
  logic [6:0]     lvl;
  logic [6:0]     stable_q, stable_d;
  logic [DBW-1:0] db_cnt_q [7];
  logic [DBW-1:0] db_cnt_d [7];
  logic [15:0]    code_q, code_d;
  logic           press_q, press_d;
  rpt_state_e     state_q, state_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;

  // Synchronised level normalised so that 1 = pressed.
  assign lvl = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  // Per-key debounce: the counter measures how long the synchronised level
  // has disagreed with the debounced level; any agreement clears it.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 7; i++) begin
      db_cnt_d[i] = '0;
      if (lvl[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = lvl[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Priority encoder: lowest-index pressed key wins.
  always_comb begin
    code_d = 16'd0;
    casez (stable_q)
      7'b??????1: code_d = 16'd130;  // left
      7'b?????10: code_d = 16'd131;  // up
      7'b????100: code_d = 16'd132;  // right
      7'b???1000: code_d = 16'd133;  // down
      7'b??10000: code_d = 16'd128;  // newline
      7'b?100000: code_d = 16'd129;  // backspace
      7'b1000000: code_d = 16'd140;  // escape
      default:    code_d = 16'd0;
    endcase
  end

  // Typematic repeat. A code change always takes precedence over a repeat
  // expiry on the same edge, so the two can never produce two pulses.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    press_d = 1'b0;
    if (code_d == 16'd0) begin
      state_d = S_IDLE;
      rcnt_d  = '0;
    end else if (code_d != code_q) begin
      press_d = 1'b1;
      rcnt_d  = '0;
      state_d = S_DELAY;
    end else begin
      case (state_q)
        S_DELAY: begin
          if (rcnt_q == RD_LAST) begin
            press_d = 1'b1;
            rcnt_d  = '0;
            state_d = S_REPEAT;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        S_REPEAT: begin
          if (rcnt_q == RR_LAST) begin
            press_d = 1'b1;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        default: begin
          // Unchanged nonzero code while idle cannot occur; hold still.
          rcnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= REL_LEVEL;
      sync2_q  <= REL_LEVEL;
      stable_q <= '0;
      code_q   <= '0;
      press_q  <= 1'b0;
      state_q  <= S_IDLE;
      rcnt_q   <= '0;
      for (int i = 0; i < 7; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= key;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      code_q   <= code_d;
      press_q  <= press_d;
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      for (int i = 0; i < 7; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  assign stable = stable_q;
  assign code   = code_q;
  assign press  = press_q;

endmodule

// File: tb/tb_key_scanner.sv
// tb_key_scanner: scoreboard bench for key_scanner with a cycle-level reference model.
// Directed button scenarios followed by randomized key patterns and reset pulses.
// Expected press events (cycle, code) are queued by the model and popped by the monitor.
module tb_key_scanner;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  key = 7'h7F;
  logic [6:0]  stable;
  logic [15:0] code;
  logic        press;

  key_scanner #(
    .DB_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key(key),
    .stable(stable),
    .code(code),
    .press(press)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] code;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;

  int key_codes [7] = '{130, 131, 132, 133, 128, 129, 140};

  function automatic logic [15:0] hack_code(input logic [6:0] s);
    logic [15:0] r;
    r = 16'd0;
    for (int i = 6; i >= 0; i--) begin
      if (s[i]) r = 16'(key_codes[i]);
    end
    return r;
  endfunction

  // Reference model: a key's debounced state flips once the last DB
  // synchronised samples all disagree with it; presses occur on a change to
  // a nonzero code, then RD cycles later and every RR cycles after that.
  logic [6:0]  m_pipe[$];
  logic [6:0]  m_win[$];
  logic [6:0]  m_stable = 7'h00;
  logic [15:0] m_code   = 16'd0;
  int          m_t0     = 0;

  always @(posedge clk) begin
    logic [6:0]  s2;
    logic [6:0]  nxt;
    logic [15:0] c;
    int          el;
    bit          all_diff;
    ev_t         ev;
    cyc++;
    if (rst) begin
      m_pipe.delete();
      m_pipe.push_back(7'h00);
      m_pipe.push_back(7'h00);
      m_win.delete();
      m_stable = 7'h00;
      m_code   = 16'd0;
    end else begin
      s2 = m_pipe.pop_front();
      m_pipe.push_back(~key);
      m_win.push_back(s2);
      if (m_win.size() > DB) void'(m_win.pop_front());
      c = hack_code(m_stable);
      if (c != 16'd0) begin
        if (c != m_code) begin
          m_t0 = cyc;
          ev.cyc = cyc; ev.code = c;
          exp_q.push_back(ev);
        end else begin
          el = cyc - m_t0;
          if (el >= RD && ((el - RD) % RR) == 0) begin
            ev.cyc = cyc; ev.code = c;
            exp_q.push_back(ev);
          end
        end
      end
      nxt = m_stable;
      if (m_win.size() == DB) begin
        for (int i = 0; i < 7; i++) begin
          all_diff = 1'b1;
          for (int j = 0; j < DB; j++) begin
            if (m_win[j][i] == m_stable[i]) all_diff = 1'b0;
          end
          if (all_diff) nxt[i] = ~m_stable[i];
        end
      end
      m_code   = c;
      m_stable = nxt;
    end
  end

  // Monitor: sample half a cycle after each active edge.
  always @(negedge clk) begin
    if (cyc > 0) begin
      checks++;
      if (stable !== m_stable) begin
        failures++;
        $display("FAIL stable cyc=%0d got=%b exp=%b", cyc, stable, m_stable);
      end
      checks++;
      if (code !== m_code) begin
        failures++;
        $display("FAIL code cyc=%0d got=%0d exp=%0d", cyc, code, m_code);
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL press_missing cyc=%0d got=0 exp_code=%0d", exp_q[0].cyc, exp_q[0].code);
        void'(exp_q.pop_front());
      end
      if (press === 1'b1) begin
        checks++;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          if (code !== exp_q[0].code) begin
            failures++;
            $display("FAIL press_code cyc=%0d got=%0d exp=%0d", cyc, code, exp_q[0].code);
          end
          void'(exp_q.pop_front());
        end else begin
          failures++;
          $display("FAIL press_unexpected cyc=%0d got=1 exp=0 code=%0d", cyc, code);
        end
      end else if (press !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL press_x cyc=%0d got=%b exp=0/1", cyc, press);
      end
    end
  end

  task automatic hold(input logic [6:0] k, input int n);
    key = k;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [6:0] k;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // All released, then a reset in the middle of a key0 debounce.
    hold(7'h7F, 50);
    hold(7'h7E, 3);
    rst = 1'b1;
    hold(7'h7E, 2);
    rst = 1'b0;
    hold(7'h7F, 20);

    // key0 press with first repeat, then release.
    hold(7'h7E, 30);
    hold(7'h7F, 20);

    // key3 glitches shorter than the debounce window.
    for (int i = 0; i < 5; i++) begin
      hold(7'h77, 3);
      hold(7'h7F, 3);
    end
    hold(7'h7F, 10);

    // key2 held through several auto-repeats.
    hold(7'h7B, 70);
    hold(7'h7F, 20);

    // key5, then key1 on top, then key1 released.
    hold(7'h5F, 30);
    hold(7'h5D, 30);
    hold(7'h5F, 30);
    hold(7'h7F, 20);

    // All keys together, released one by one from key0 upward.
    hold(7'h00, 30);
    for (int i = 0; i < 7; i++) begin
      k = 7'h7F;
      k = k >> (6 - i);
      hold(k, 12);
    end
    hold(7'h7F, 20);

    // Randomized patterns, mostly one or two keys down, occasional resets.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 19) == 0) pulse_reset($urandom_range(1, 3));
      k = 7'h7F & ~(7'($urandom) & 7'($urandom));
      hold(k, $urandom_range(1, 30));
    end
    hold(7'h7F, 40);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL press_leftover got=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_scanner.md
Name: key_scanner

Overview:
- Input stage of the FPGA computer. Sits between the seven board push-buttons and the memory-mapped keyboard register of the computer's memory/peripheral block.
- Synchronises, debounces and priority-encodes the buttons into a 16-bit keyboard code, using Hack character codes.
- Raises a one-cycle press strobe on each new key-down and on typematic auto-repeat, so software and peripherals see clean, repeatable key events.

Parameters:
- DB_CYCLES, 1000000: consecutive cycles a synchronised key level must differ from its debounced level before the debounced level flips (>=2).
- REPEAT_DELAY, 50000000: cycles from the initial press strobe to the first auto-repeat strobe.
- REPEAT_RATE, 10000000: cycles between subsequent auto-repeat strobes.
- ACTIVE_LOW, 1: 1 means raw key=0 is pressed; 0 means raw key=1 is pressed.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- key  in  7  raw asynchronous push-button levels.
- stable  out  7  debounced key state, 1 = pressed.
- code  out  16  current keyboard code, 0 = no key.
- press  out  1  one-cycle strobe: new key code or auto-repeat.

Behaviour:
- Reset, synchronous on rst=1 at a rising edge:
  - Synchroniser flops load the released level (1 if ACTIVE_LOW, else 0).
  - Debounce counters = 0; stable = 7'b0; code = 16'd0; press = 0; repeat FSM = IDLE, repeat counter = 0.
  - rst mid-debounce or mid-repeat aborts everything. No press is generated on the edge after reset is released.
- Synchroniser: two flops per key, then polarity normalisation to 1 = pressed.
- Debounce, per key, independent:
  - Each edge where the synchronised level s2 != stable[i]: if cnt == DB_CYCLES-1, stable[i] <= s2 and cnt <= 0; otherwise cnt++.
  - Each edge where s2 == stable[i]: cnt <= 0. A glitch shorter than DB_CYCLES cycles never changes stable.
  - Latency: a raw change first sampled at edge 1 appears on stable at edge 2+DB_CYCLES.
- Encoder (combinational from stable, registered into code one edge later):
  - Lowest-index pressed key wins.
  - Mapping: key0=130 (left), key1=131 (up), key2=132 (right), key3=133 (down), key4=128 (newline), key5=129 (backspace), key6=140 (escape).
  - No key pressed: 0. code[15:8] is always 0.
  - code is therefore valid at edge 3+DB_CYCLES after the raw change.
- Repeat FSM, states IDLE, DELAY, REPEAT, with one counter rcnt:
  - Any state, next code == 0: go to IDLE, press=0.
  - Next code nonzero and != current code (new key, or priority switch between keys): press=1 in the same cycle code updates, rcnt=0, go to DELAY.
  - DELAY, code unchanged: rcnt++; at rcnt == REPEAT_DELAY-1, press=1, rcnt=0, go to REPEAT.
  - REPEAT, code unchanged: rcnt++; at rcnt == REPEAT_RATE-1, press=1, rcnt=0.
  - A new-code event and a repeat expiry on the same edge produce one press pulse; the new-code rule wins and restarts DELAY.
  - press is high for exactly one cycle per event. It is never asserted while code == 0.
- Releasing a higher-priority key while a lower one is still held switches code to the lower key's code, with press and DELAY restart.
- Counter widths: sized by $clog2 of the respective parameter; no wrap-around is reachable.

Test Plan (parameters overridden: DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8, ACTIVE_LOW=1):
1. Reset, then key=7'h7F held 50 cycles -> stable=0, code=0, press never 1. Assert rst mid-debounce of key0 -> stable stays 0 and code stays 0 after reset is released.
2. key0 low, first sampled at edge 1, held -> stable=7'b0000001 at edge 6; code=130 and press=1 at edge 7 only.
3. key3 low for 3 cycles then high; repeat 5 times -> stable, code and press never change.
4. key2 held 60 cycles past code=132 -> press pulses at the initial edge, +20, +28, +36, +44, +52, each one cycle wide. Release -> code=0 at the 3+DB_CYCLES edge after release, no pulse.
5. key5 held, then key1 also pressed -> code 129 -> 131 with press on the switch. Release key1 -> code returns to 129 with press, and the DELAY count restarts from 0.
6. All seven keys pressed together -> code=130 with a single press. Release keys one by one from key0 upward -> code steps 131, 132, 133, 128, 129, 140, 0, each nonzero step with one press.
